// File: rtl/code_loader_rom.sv
// code_loader_rom: instruction memory with combinational fetch, filled by a byte-serial checksummed image loader
// Ports:
//    clock, reset  system clock, synchronous active-high reset
//    code_addr     fetch address from the core
//    code_word     instruction at code_addr (0 when out of range)
//    rx_data       load byte
//    rx_valid      rx_data is valid
//    rx_ready      loader accepts a byte (low only while writing a word)
//    cpu_reset     core reset, released only after a clean load
//    load_busy     a load is in progress
//    load_done     last load completed with a valid checksum
//    load_error    last load aborted
module code_loader_rom #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18,
   parameter int MEM_SIZE  = 1024
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ADDR_SIZE-1:0] code_addr,
   output logic [WORD_SIZE-1:0] code_word,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   output logic                 cpu_reset,
   output logic                 load_busy,
   output logic                 load_done,
   output logic                 load_error
);
   localparam int MW = $clog2(MEM_SIZE);
   localparam logic [15:0] MAX_N = 16'(MEM_SIZE);
   localparam logic [ADDR_SIZE:0] LIMIT = (ADDR_SIZE+1)'(MEM_SIZE);
   typedef enum logic [3:0] {IDLE, CNT_LO, CNT_HI, B0, B1, B2, WRITE, CSUM, DONE, ERROR} state_t;
   state_t state;
   logic [WORD_SIZE-1:0] mem [MEM_SIZE];
   logic [15:0] count, waddr;
   logic [7:0] csum;
   logic [17:0] word;
   logic [15:0] n_next;
   assign n_next = {rx_data, count[7:0]};
   assign code_word = ({1'b0, code_addr} < LIMIT) ? mem[code_addr[MW-1:0]] : '0;
   assign rx_ready = state != WRITE;
   assign load_busy = !(state inside {IDLE, DONE, ERROR});
   // Registered write port: a same-cycle fetch of this address still sees the old word.
   always_ff @(posedge clock)
      if (!reset && state == WRITE) mem[waddr[MW-1:0]] <= word;
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         waddr      <= '0;
         csum       <= '0;
         count      <= '0;
         word       <= '0;
      end else if (state == WRITE) begin
         if (waddr == count - 16'd1) state <= CSUM;
         else begin
            waddr <= waddr + 16'd1;
            state <= B0;
         end
      end else if (rx_valid) begin
         case (state)
            IDLE, DONE, ERROR:
               if (rx_data == 8'hA5) begin
                  state      <= CNT_LO;
                  csum       <= '0;
                  waddr      <= '0;
                  load_done  <= 1'b0;
                  load_error <= 1'b0;
                  cpu_reset  <= 1'b1;
               end
            CNT_LO: begin
               count[7:0] <= rx_data;
               csum       <= csum ^ rx_data;
               state      <= CNT_HI;
            end
            CNT_HI: begin
               count[15:8] <= rx_data;
               csum        <= csum ^ rx_data;
               if (n_next == 16'd0 || n_next > MAX_N) begin
                  state      <= ERROR;
                  load_error <= 1'b1;
               end else state <= B0;
            end
            B0: begin
               word[7:0] <= rx_data;
               csum      <= csum ^ rx_data;
               state     <= B1;
            end
            B1: begin
               word[15:8] <= rx_data;
               csum       <= csum ^ rx_data;
               state      <= B2;
            end
            B2:
               // Only bits [1:0] of the top byte carry data; anything else is a corrupt image.
               if (rx_data[7:2] != 6'd0) begin
                  state      <= ERROR;
                  load_error <= 1'b1;
               end else begin
                  word[17:16] <= rx_data[1:0];
                  csum        <= csum ^ rx_data;
                  state       <= WRITE;
               end
            CSUM:
               if (rx_data == csum) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  state      <= ERROR;
                  load_error <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
